// File: rtl/iot_event_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// iot_pkg
// Shared defaults and types for the IoT event arbiter slice.
//   N_DEV_DEF       : default number of monitored device lines
//   SYNC_STAGES_DEF : default depth of the per-line input synchroniser
//   dir_t           : direction of a device event (connect / disconnect)
// ---------------------------------------------------------------------------
package iot_pkg;

    localparam int N_DEV_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {
        DIR_OFF = 1'b0,   // disconnect: monitor decrements
        DIR_ON  = 1'b1    // connect:    monitor increments
    } dir_t;

endpackage

// File: rtl/iot_event_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. Returns the first asserted
// request found when searching ptr, ptr+1, ... with wrap modulo N.
//   req       : request vector
//   ptr       : search start index (must be < N)
//   gnt       : one-hot grant
//   gnt_idx   : index of the granted request (0 when none)
//   gnt_valid : at least one request was granted
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx,
    output logic           gnt_valid
);

    // One extra bit holds ptr+k before the wrap; ptr < N keeps the sum
    // below 2N-1, so a single conditional subtract is a full modulo.
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N))
                sum = sum - (IDW+1)'(N);
            idx = sum[IDW-1:0];
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
                gnt[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iot_event_arbiter.sv
// ---------------------------------------------------------------------------
// iot_event_arbiter
// Watches N_DEV asynchronous "device active" lines, turns their connect /
// disconnect edges into at most one net pending event per device, and
// serialises those events round-robin into single-cycle change/on_off
// pulses that drive the active-device counter directly.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   dev_active : per-device level, 1 = connected (asynchronous to clk)
//   en         : 1 = grants allowed, 0 = hold everything pending
//   change     : one-cycle pulse, an event is presented
//   on_off     : event direction with change (1 = connect)
//   dev_id     : device index of the presented event
//   busy       : registered OR of all pending flags
// ---------------------------------------------------------------------------
module iot_event_arbiter
    import iot_pkg::*;
#(
    parameter int N_DEV       = N_DEV_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int ID_W        = $clog2(N_DEV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_active,
    input  logic             en,
    output logic             change,
    output logic             on_off,
    output logic [ID_W-1:0]  dev_id,
    output logic             busy
);

    // -- synchroniser and edge detect --------------------------------------
    logic [SYNC_STAGES-1:0][N_DEV-1:0] sync_q;
    logic [N_DEV-1:0] s, prev, rise, fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], dev_active};
            prev   <= s;
        end
    end

    // prev resets low, so a line held high through reset reports a connect.
    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev;
    assign fall = ~s & prev;

    // -- arbitration --------------------------------------------------------
    logic [N_DEV-1:0] pend_valid, pend_dir;
    logic [N_DEV-1:0] pend_valid_nxt, pend_dir_nxt;
    logic [N_DEV-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx, ptr;
    logic             gnt_valid;

    rr_arbiter #(.N(N_DEV), .IDW(ID_W)) u_rr (
        .req       (pend_valid & {N_DEV{en}}),
        .ptr       (ptr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // -- pending update -----------------------------------------------------
    // The grant consumes the flag first; an edge landing on the same clock
    // then starts a fresh event rather than being lost. An edge opposite to
    // a still-pending event cancels it, since the two net to zero.
    logic held;

    always_comb begin
        pend_valid_nxt = '0;
        pend_dir_nxt   = pend_dir;
        held           = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            held              = pend_valid[i] & ~gnt[i];
            pend_valid_nxt[i] = held;
            if (rise[i] || fall[i]) begin
                if (!held) begin
                    pend_valid_nxt[i] = 1'b1;
                    pend_dir_nxt[i]   = rise[i] ? DIR_ON : DIR_OFF;
                end else if (pend_dir[i] != rise[i]) begin
                    pend_valid_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= '0;
            pend_dir   <= '0;
            busy       <= 1'b0;
        end else begin
            pend_valid <= pend_valid_nxt;
            pend_dir   <= pend_dir_nxt;
            busy       <= |pend_valid_nxt;
        end
    end

    // -- output register ----------------------------------------------------
    // on_off and dev_id keep their last values between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            change <= 1'b0;
            on_off <= 1'b0;
            dev_id <= '0;
            ptr    <= '0;
        end else begin
            change <= gnt_valid;
            if (gnt_valid) begin
                on_off <= pend_dir[gnt_idx];
                dev_id <= gnt_idx;
                ptr    <= (gnt_idx == ID_W'(N_DEV-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iot_event_arbiter.sv
module tb_iot_event_arbiter;

    localparam int N    = 8;
    localparam int SYNC = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] dev_active = 8'h05;
    logic         en = 1'b1;
    logic         change, on_off, busy;
    logic [2:0]   dev_id;

    iot_event_arbiter #(.N_DEV(N), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .dev_active (dev_active),
        .en         (en),
        .change     (change),
        .on_off     (on_off),
        .dev_id     (dev_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int sum     = 0;   // running monitor count

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---- reference model ------------------------------------------------
    // lvl = line level as seen after the synchroniser delay; rep = level the
    // monitor has been told about. A device has a pending event exactly when
    // the two differ, and its direction is the seen level.
    logic [N-1:0] m_samp [SYNC];
    logic [N-1:0] m_lvl, m_rep;
    int           m_ptr;
    logic         m_chg, m_on, m_busy;
    int           m_id;

    task automatic model_reset();
        for (int k = 0; k < SYNC; k++) m_samp[k] = '0;
        m_lvl = '0; m_rep = '0; m_ptr = 0;
        m_chg = 0; m_on = 0; m_busy = 0; m_id = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] pend;
        logic         found;
        int           g;
        pend  = m_lvl ^ m_rep;
        found = 0;
        m_chg = 0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                g = (m_ptr + k) % N;
                if (!found && pend[g]) begin
                    found    = 1;
                    m_chg    = 1;
                    m_on     = m_lvl[g];
                    m_id     = g;
                    m_rep[g] = m_lvl[g];
                    m_ptr    = (g + 1) % N;
                end
            end
        end
        m_lvl = m_samp[SYNC-1];
        for (int k = SYNC-1; k > 0; k--) m_samp[k] = m_samp[k-1];
        m_samp[0] = dev_active;
        m_busy = |(m_lvl ^ m_rep);
    endtask

    // One clock: advance model at the edge, compare #1 later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("change", int'(change), int'(m_chg));
        chk("on_off", int'(on_off), int'(m_on));
        chk("dev_id", int'(dev_id), m_id);
        chk("busy",   int'(busy),   int'(m_busy));
        if (change) sum += on_off ? 1 : -1;
    endtask

    task automatic do_reset(input logic [N-1:0] da, input logic e);
        dev_active = da;
        en  = e;
        rst = 1'b1;
        model_reset();
        sum = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] da;
        logic         en;
        logic         chg;
        logic         on;
        int           id;
        logic         busy;
    } vec_t;

    vec_t tv [16];
    int   pulses, ids_ok;

    initial begin
        // reset release with 0 and 2 held, then device 3 up and down
        tv[0]  = '{8'h05, 1, 0, 0, 0, 0};
        tv[1]  = '{8'h05, 1, 0, 0, 0, 0};
        tv[2]  = '{8'h05, 1, 0, 0, 0, 1};
        tv[3]  = '{8'h05, 1, 1, 1, 0, 1};
        tv[4]  = '{8'h05, 1, 1, 1, 2, 0};
        tv[5]  = '{8'h05, 1, 0, 1, 2, 0};
        tv[6]  = '{8'h0D, 1, 0, 1, 2, 0};
        tv[7]  = '{8'h0D, 1, 0, 1, 2, 0};
        tv[8]  = '{8'h0D, 1, 0, 1, 2, 1};
        tv[9]  = '{8'h0D, 1, 1, 1, 3, 0};
        tv[10] = '{8'h0D, 1, 0, 1, 3, 0};
        tv[11] = '{8'h05, 1, 0, 1, 3, 0};
        tv[12] = '{8'h05, 1, 0, 1, 3, 0};
        tv[13] = '{8'h05, 1, 0, 1, 3, 1};
        tv[14] = '{8'h05, 1, 1, 0, 3, 0};
        tv[15] = '{8'h05, 1, 0, 0, 3, 0};

        model_reset();
        #3;
        chk("rst_change", int'(change), 0);
        chk("rst_on_off", int'(on_off), 0);
        chk("rst_dev_id", int'(dev_id), 0);
        chk("rst_busy",   int'(busy),   0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            dev_active = tv[i].da;
            en         = tv[i].en;
            step();
            chk("tv_change", int'(change), int'(tv[i].chg));
            chk("tv_on_off", int'(on_off), int'(tv[i].on));
            chk("tv_dev_id", int'(dev_id), tv[i].id);
            chk("tv_busy",   int'(busy),   int'(tv[i].busy));
            if (i == 5) chk("count_after_reset", sum, 2);
        end
        chk("count_after_dev3", sum, 2);

        // cancel: device 5 up and down while en=0
        en = 1'b0; pulses = 0;
        dev_active = 8'h25;
        repeat (3) begin step(); pulses += int'(change); end
        dev_active = 8'h05;
        repeat (6) begin step(); pulses += int'(change); end
        en = 1'b1;
        repeat (4) begin step(); pulses += int'(change); end
        chk("cancel_pulses", pulses, 0);
        chk("cancel_busy", int'(busy), 0);

        // fairness: all lines pending, then 8 back-to-back grants
        do_reset(8'h00, 1'b0);
        dev_active = 8'hFF;
        repeat (5) step();
        en = 1'b1;
        for (int k = 0; k < N; k++) begin
            step();
            chk("fair_change", int'(change), 1);
            chk("fair_id", int'(dev_id), k);
            chk("fair_on", int'(on_off), 1);
        end
        step();
        chk("fair_end_change", int'(change), 0);
        chk("fair_end_busy", int'(busy), 0);

        // grant/edge race on device 1
        do_reset(8'h00, 1'b0);
        dev_active = 8'h02;
        repeat (5) step();
        dev_active = 8'h00;
        step(); step();
        en = 1'b1;
        step();
        chk("race_g1_change", int'(change), 1);
        chk("race_g1_id", int'(dev_id), 1);
        chk("race_g1_on", int'(on_off), 1);
        step();
        chk("race_g2_change", int'(change), 1);
        chk("race_g2_id", int'(dev_id), 1);
        chk("race_g2_on", int'(on_off), 0);
        step();
        chk("race_net", sum, 0);
        chk("race_busy", int'(busy), 0);

        // asynchronous reset in the middle of a burst
        do_reset(8'h00, 1'b0);
        dev_active = 8'hFF;
        repeat (5) step();
        en = 1'b1;
        step(); step();
        #6;
        rst = 1'b1;
        #1;
        chk("arst_change", int'(change), 0);
        chk("arst_busy",   int'(busy),   0);
        chk("arst_dev_id", int'(dev_id), 0);
        model_reset();
        sum = 0;
        #14;
        rst = 1'b0;
        pulses = 0; ids_ok = 0;
        repeat (14) begin
            step();
            if (change && on_off) begin
                if (int'(dev_id) == pulses) ids_ok++;
                pulses++;
            end
        end
        chk("arst_pulses", pulses, 8);
        chk("arst_order", ids_ok, 8);
        chk("arst_count", sum, 8);

        // randomized traffic against the model
        do_reset(8'h00, 1'b1);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0)
                dev_active[$urandom_range(0, N-1)] ^= 1'b1;
            en = ($urandom_range(0, 3) != 0);
            step();
        end
        en = 1'b1;
        repeat (20) step();
        chk("drain_busy", int'(busy), 0);
        chk("invariant", sum, $countones(dev_active));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
